// File: rtl/pipeline_dmem_stall_unit_pkg.sv
// rtl/pipeline_dmem_stall_unit_pkg.sv - shared access-size codes and FSM encodings for the MEM-stage data-memory unit
package pipeline_dmem_stall_unit_pkg;

    // funct3 access-size codes (RISC-V load/store encoding)
    localparam logic [2:0] MEM_BYTE   = 3'b000;
    localparam logic [2:0] MEM_HALF   = 3'b001;
    localparam logic [2:0] MEM_WORD   = 3'b010;
    localparam logic [2:0] MEM_BYTE_U = 3'b100;
    localparam logic [2:0] MEM_HALF_U = 3'b101;

    // Access FSM: IDLE issues, WAIT holds the request, DONE holds the result
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } dmem_state_t;

endpackage

// File: rtl/pipeline_dmem_stall_unit_lane_align.sv
// rtl/pipeline_dmem_stall_unit_lane_align.sv - byte-lane steering, load extension and access legality check
module dmem_lane_align
    import pipeline_dmem_stall_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [1:0]  byte_offset,
    input  logic [31:0] write_data,
    input  logic [31:0] read_data,
    output logic [3:0]  byte_enable,
    output logic [31:0] lane_write_data,
    output logic [31:0] load_data,
    output logic        access_bad
);

    logic [31:0] shifted_read;

    // Read word is shifted down so the addressed byte/half sits at bit 0.
    assign shifted_read = read_data >> {byte_offset, 3'b000};

    // Decode size: lanes, replicated store data, extended load data, legality
    always_comb begin
        byte_enable     = 4'b0000;
        lane_write_data = 32'h0000_0000;
        load_data       = 32'h0000_0000;
        access_bad      = 1'b0;
        case (funct3)
            MEM_BYTE, MEM_BYTE_U: begin
                byte_enable     = 4'b0001 << byte_offset;
                lane_write_data = {4{write_data[7:0]}};
                if (funct3 == MEM_BYTE) begin
                    load_data = {{24{shifted_read[7]}}, shifted_read[7:0]};
                end else begin
                    load_data = {24'h00_0000, shifted_read[7:0]};
                end
                access_bad = is_store && (funct3 == MEM_BYTE_U);
            end
            MEM_HALF, MEM_HALF_U: begin
                byte_enable     = byte_offset[1] ? 4'b1100 : 4'b0011;
                lane_write_data = {2{write_data[15:0]}};
                if (funct3 == MEM_HALF) begin
                    load_data = {{16{shifted_read[15]}}, shifted_read[15:0]};
                end else begin
                    load_data = {16'h0000, shifted_read[15:0]};
                end
                access_bad = byte_offset[0] || (is_store && (funct3 == MEM_HALF_U));
            end
            MEM_WORD: begin
                byte_enable     = 4'b1111;
                lane_write_data = write_data;
                load_data       = read_data;
                access_bad      = (byte_offset != 2'b00);
            end
            default: begin
                access_bad = 1'b1;
            end
        endcase
        // An illegal access never drives lanes, even though the request is also gated.
        if (access_bad) begin
            byte_enable = 4'b0000;
        end
    end

endmodule

// File: rtl/pipeline_dmem_stall_unit.sv
// rtl/pipeline_dmem_stall_unit.sv - MEM-stage data-memory access unit with stall, timeout and fault reporting
module pipeline_dmem_stall_unit
    import pipeline_dmem_stall_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int COUNT_WIDTH    = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read_enable,
    input  logic        mem_write_enable,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_write_data,
    input  logic [2:0]  mem_funct3,
    input  logic        advance,
    output logic        want_stall,
    output logic [31:0] mem_read_data,
    output logic        access_fault,
    output logic        bus_valid,
    output logic        bus_write,
    output logic [31:0] bus_address,
    output logic [3:0]  bus_byte_enable,
    output logic [31:0] bus_write_data,
    input  logic        bus_ready,
    input  logic [31:0] bus_read_data
);

    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_VAL = COUNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic                   TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE   = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX   = {COUNT_WIDTH{1'b1}};

    dmem_state_t            state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   fault_q, fault_d;

    logic        op;
    logic        bad;
    logic        align_bad;
    logic [31:0] load_data;

    dmem_lane_align u_lane_align (
        .funct3          (mem_funct3),
        .is_store        (mem_write_enable),
        .byte_offset     (mem_address[1:0]),
        .write_data      (mem_write_data),
        .read_data       (bus_read_data),
        .byte_enable     (bus_byte_enable),
        .lane_write_data (bus_write_data),
        .load_data       (load_data),
        .access_bad      (align_bad)
    );

    assign op  = mem_read_enable | mem_write_enable;
    assign bad = align_bad | (mem_read_enable & mem_write_enable);

    // Bus side is combinational from the MEM inputs, which the stall holds stable.
    assign bus_write   = mem_write_enable;
    assign bus_address = {mem_address[31:2], 2'b00};
    assign bus_valid   = op & ~bad & ((state_q == ST_IDLE) | (state_q == ST_WAIT));
    assign want_stall  = op & (state_q != ST_DONE);

    assign mem_read_data = rdata_q;
    assign access_fault  = fault_q;

    // State, timeout counter and registered response
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            rdata_q <= 32'h0000_0000;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // Next-state: issue, wait with timeout, hold result until the instruction advances
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (op) begin
                    if (bad) begin
                        fault_d = 1'b1;
                        state_d = ST_DONE;
                    end else if (bus_ready) begin
                        if (mem_read_enable) begin
                            rdata_d = load_data;
                        end
                        fault_d = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        count_d = COUNT_ONE;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // A response on the timeout cycle still completes cleanly.
                if (bus_ready) begin
                    if (mem_read_enable) begin
                        rdata_d = load_data;
                    end
                    fault_d = 1'b0;
                    state_d = ST_DONE;
                end else if (TIMEOUT_EN && (count_q == TIMEOUT_VAL)) begin
                    fault_d = 1'b1;
                    state_d = ST_DONE;
                end else if (count_q != COUNT_MAX) begin
                    count_d = count_q + COUNT_ONE;
                end
            end
            ST_DONE: begin
                // Returning to IDLE lets the next instruction start fresh; no reissue.
                if (advance) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pipeline_dmem_stall_unit.sv
// tb/tb_pipeline_dmem_stall_unit.sv - directed self-checking bench for pipeline_dmem_stall_unit
module tb_pipeline_dmem_stall_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_read_enable = 1'b0;
    logic        mem_write_enable = 1'b0;
    logic [31:0] mem_address = 32'h0;
    logic [31:0] mem_write_data = 32'h0;
    logic [2:0]  mem_funct3 = 3'b000;
    logic        advance = 1'b0;
    logic        want_stall;
    logic [31:0] mem_read_data;
    logic        access_fault;
    logic        bus_valid;
    logic        bus_write;
    logic [31:0] bus_address;
    logic [3:0]  bus_byte_enable;
    logic [31:0] bus_write_data;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_read_data = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;
    int stalls;
    int valids;

    pipeline_dmem_stall_unit #(
        .TIMEOUT_CYCLES (4),
        .COUNT_WIDTH    (8)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_funct3       (mem_funct3),
        .advance          (advance),
        .want_stall       (want_stall),
        .mem_read_data    (mem_read_data),
        .access_fault     (access_fault),
        .bus_valid        (bus_valid),
        .bus_write        (bus_write),
        .bus_address      (bus_address),
        .bus_byte_enable  (bus_byte_enable),
        .bus_write_data   (bus_write_data),
        .bus_ready        (bus_ready),
        .bus_read_data    (bus_read_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Walk the access from IDLE until want_stall drops, raising bus_ready on
    // cycle ready_after (cycle 0 is the IDLE issue cycle; -1 means never).
    task automatic run_op(input int ready_after, output int n_stall, output int n_valid);
        n_stall = 0;
        n_valid = 0;
        for (int i = 0; i < 20; i++) begin
            bus_ready = (i == ready_after);
            #1;
            if (!want_stall) break;
            n_stall++;
            if (bus_valid) n_valid++;
            @(posedge clock);
            #1;
        end
        bus_ready = 1'b0;
    endtask

    task automatic retire();
        advance = 1'b1;
        tick();
        advance = 1'b0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata);
        mem_read_enable  = rd;
        mem_write_enable = wr;
        mem_funct3       = f3;
        mem_address      = addr;
        mem_write_data   = wdata;
        bus_read_data    = rdata;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_want_stall", 32'(want_stall), 32'd0);
        chk("rst_bus_valid", 32'(bus_valid), 32'd0);
        chk("rst_read_data", mem_read_data, 32'h0);
        chk("rst_fault", 32'(access_fault), 32'd0);
        reset = 1'b0;
        tick();

        // LW 0x100, ready on first request cycle
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF);
        #1;
        chk("lw_be", 32'(bus_byte_enable), 32'hF);
        chk("lw_addr", bus_address, 32'h0000_0100);
        chk("lw_write", 32'(bus_write), 32'd0);
        run_op(0, stalls, valids);
        chk("lw_stalls", 32'(stalls), 32'd1);
        chk("lw_data", mem_read_data, 32'hDEAD_BEEF);
        chk("lw_fault", 32'(access_fault), 32'd0);
        chk("lw_done_valid", 32'(bus_valid), 32'd0);
        retire();

        // LB 0x103, ready after 3 WAIT cycles
        set_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FFFF);
        #1;
        chk("lb_be", 32'(bus_byte_enable), 32'h8);
        run_op(3, stalls, valids);
        chk("lb_stalls", 32'(stalls), 32'd4);
        chk("lb_data", mem_read_data, 32'hFFFF_FF80);
        retire();

        // LBU 0x103, same timing
        set_op(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_FFFF);
        run_op(3, stalls, valids);
        chk("lbu_stalls", 32'(stalls), 32'd4);
        chk("lbu_data", mem_read_data, 32'h0000_0080);
        retire();

        // SH 0x102
        set_op(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h0);
        #1;
        chk("sh_write", 32'(bus_write), 32'd1);
        chk("sh_be", 32'(bus_byte_enable), 32'hC);
        chk("sh_wdata_hi", 32'(bus_write_data[31:16]), 32'h1234);
        run_op(0, stalls, valids);
        chk("sh_stalls", 32'(stalls), 32'd1);
        chk("sh_fault", 32'(access_fault), 32'd0);
        chk("sh_rdata_kept", mem_read_data, 32'h0000_0080);
        retire();

        // SH 0x101 misaligned
        set_op(1'b0, 1'b1, 3'b001, 32'h0000_0101, 32'h0000_1234, 32'h0);
        run_op(0, stalls, valids);
        chk("sh_mis_valids", 32'(valids), 32'd0);
        chk("sh_mis_stalls", 32'(stalls), 32'd1);
        chk("sh_mis_fault", 32'(access_fault), 32'd1);
        retire();

        // Illegal funct3 011, store with unsigned size, both enables
        set_op(1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0, 32'h0);
        run_op(0, stalls, valids);
        chk("f3_011_valids", 32'(valids), 32'd0);
        chk("f3_011_fault", 32'(access_fault), 32'd1);
        retire();
        set_op(1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0, 32'h0);
        run_op(0, stalls, valids);
        chk("sbu_valids", 32'(valids), 32'd0);
        chk("sbu_fault", 32'(access_fault), 32'd1);
        retire();
        set_op(1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'h0, 32'h0);
        run_op(0, stalls, valids);
        chk("both_valids", 32'(valids), 32'd0);
        chk("both_fault", 32'(access_fault), 32'd1);
        chk("both_rdata_kept", mem_read_data, 32'h0000_0080);
        retire();

        // Timeout: bus never ready
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h0);
        run_op(-1, stalls, valids);
        chk("to_valids", 32'(valids), 32'd5);
        chk("to_stalls", 32'(stalls), 32'd5);
        chk("to_fault", 32'(access_fault), 32'd1);
        chk("to_done_valid", 32'(bus_valid), 32'd0);
        retire();

        // Ready on exactly the timeout cycle wins
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h1122_3344);
        run_op(4, stalls, valids);
        chk("to_edge_stalls", 32'(stalls), 32'd5);
        chk("to_edge_fault", 32'(access_fault), 32'd0);
        chk("to_edge_data", mem_read_data, 32'h1122_3344);
        retire();

        // LW held in DONE while advance stays low
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'hCAFE_F00D);
        run_op(0, stalls, valids);
        bus_read_data = 32'h0;
        for (int k = 0; k < 3; k++) begin
            chk("hold_stall", 32'(want_stall), 32'd0);
            chk("hold_valid", 32'(bus_valid), 32'd0);
            chk("hold_data", mem_read_data, 32'hCAFE_F00D);
            tick();
        end
        advance = 1'b1;
        tick();
        advance = 1'b0;
        set_op(1'b1, 1'b0, 3'b010, 32'h0000_0304, 32'h0, 32'h5555_AAAA);
        #1;
        chk("b2b_valid", 32'(bus_valid), 32'd1);
        chk("b2b_stall", 32'(want_stall), 32'd1);
        chk("b2b_addr", bus_address, 32'h0000_0304);
        run_op(0, stalls, valids);
        chk("b2b_data", mem_read_data, 32'h5555_AAAA);
        retire();

        // Reset while in WAIT
        set_op(1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h8001_0000);
        tick();
        chk("rw_wait_stall", 32'(want_stall), 32'd1);
        reset = 1'b1;
        tick();
        mem_read_enable = 1'b0;
        #1;
        chk("rw_stall", 32'(want_stall), 32'd0);
        chk("rw_valid", 32'(bus_valid), 32'd0);
        chk("rw_data", mem_read_data, 32'h0);
        chk("rw_fault", 32'(access_fault), 32'd0);
        reset = 1'b0;
        mem_read_enable = 1'b1;
        #1;
        chk("rw_reissue_valid", 32'(bus_valid), 32'd1);
        run_op(0, stalls, valids);
        chk("lh_data", mem_read_data, 32'hFFFF_8001);
        retire();

        // LHU upper half
        set_op(1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0, 32'h8001_0000);
        run_op(0, stalls, valids);
        chk("lhu_data", mem_read_data, 32'h0000_8001);
        retire();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_dmem_stall_unit.md
Name: pipeline_dmem_stall_unit

Overview:
MEM-stage data-memory access unit for the pipelined core. It turns the control path's data_mem_read_enable / data_mem_write_enable into a valid/ready bus transaction with byte-lane steering, and raises want_stall while the access is in flight. Load data is sign- or zero-extended and held until the MEM instruction actually advances. Misaligned, illegal and timed-out accesses are reported through access_fault.

Parameters:
TIMEOUT_CYCLES, 255, WAIT cycles without bus_ready before the access is abandoned with a fault; 0 disables the timeout.
COUNT_WIDTH, 8, width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**COUNT_WIDTH.

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high reset
mem_read_enable  in  1  MEM-stage load (control path data_mem_read_enable)
mem_write_enable  in  1  MEM-stage store (control path data_mem_write_enable)
mem_address  in  32  byte address
mem_write_data  in  32  store data, right-aligned
mem_funct3  in  3  access size and signedness
advance  in  1  MEM instruction leaves the stage this cycle (pipeline no_stall)
want_stall  out  1  to control path want_stall
mem_read_data  out  32  extended load result, registered
access_fault  out  1  misaligned, illegal or timeout; registered
bus_valid  out  1  bus request
bus_write  out  1  1 = store
bus_address  out  32  word-aligned address ({mem_address[31:2],2'b00})
bus_byte_enable  out  4  active byte lanes
bus_write_data  out  32  lane-shifted store data
bus_ready  in  1  bus accepts/completes the request this cycle
bus_read_data  in  32  word read data, valid with bus_ready on loads

Behaviour:
- Reset: state IDLE, counter 0, mem_read_data 0, access_fault 0, bus_valid 0. With no MEM op present, want_stall is 0.
- op = mem_read_enable | mem_write_enable.
- bad = any of the following:
  - both read and write enables set;
  - mem_funct3 is 011, 110 or 111 (or 100/101 on a store);
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0.
- Lanes: byte access uses 1<<addr[1:0]; halfword uses 0011 or 1100 selected by addr[1]; word uses 1111. Write data is replicated and shifted onto the lanes.
- Load extract: select by addr[1:0] and size. Sign-extend for 000/001; zero-extend for 100/101.
- want_stall = op & (state != DONE). Every memory op therefore stalls at least one cycle, because the response is registered.
- bus_valid = op & !bad & (state == IDLE | state == WAIT). All bus outputs are combinational from the MEM inputs, which are held stable by the stall.
- IDLE:
  - op & bad: go to DONE, access_fault=1, no bus request.
  - op & !bad & bus_ready: capture extended data (loads), access_fault=0, go to DONE.
  - op & !bad & !bus_ready: go to WAIT, counter=1.
  - no op: stay in IDLE.
- WAIT:
  - bus_ready: capture, access_fault=0, go to DONE.
  - else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES: access_fault=1, go to DONE; bus_valid drops.
  - else counter+1.
  - If bus_ready and the timeout coincide, bus_ready wins (no fault).
- DONE:
  - want_stall=0; mem_read_data and access_fault are stable.
  - advance=1: go to IDLE. The next instruction is evaluated fresh in IDLE, so a completed op is never reissued.
  - advance=0 (another stall source): stay in DONE, no new bus request.
- Stores: mem_read_data is left unchanged; only access_fault updates.
- Reset mid-WAIT: return to IDLE immediately and drop bus_valid; the bus side is reset by the same reset.
- The counter never wraps; it is cleared on every IDLE->WAIT entry.

Decomposition:
- constants.sv gains:
  - funct3 width codes (`MEM_BYTE`, `MEM_HALF`, `MEM_WORD`, `MEM_BYTE_U`, `MEM_HALF_U`);
  - state encodings for IDLE/WAIT/DONE (2-bit).
- One combinational sub-module, dmem_lane_align, computes from mem_funct3/mem_address/mem_write_data/bus_read_data:
  - bus_byte_enable;
  - shifted write data;
  - extended load data;
  - misaligned/illegal flag.
- The FSM and timeout counter stay in the top module.

Test Plan:
- LW addr 0x100, bus_ready on first request cycle, bus_read_data 0xDEADBEEF -> want_stall high 1 cycle; DONE: mem_read_data 0xDEADBEEF, fault 0, bus_byte_enable 1111.
- LB addr 0x103, data 0x80FFFFFF, ready after 3 WAIT cycles -> byte_enable 1000, want_stall 4 cycles, mem_read_data 0xFFFFFF80; repeat as LBU -> 0x00000080.
- SH addr 0x102, data 0x1234 -> bus_write 1, byte_enable 1100, bus_write_data[31:16]=0x1234; SH addr 0x101 -> no bus_valid, 1 stall cycle, access_fault 1.
- TIMEOUT_CYCLES=4, bus_ready never -> bus_valid for 5 cycles then drops; DONE with fault 1. Ready arriving exactly at the timeout cycle -> fault 0.
- LW completes while advance=0 for 3 cycles -> stays in DONE, bus_valid 0, data held; back-to-back LW after advance -> a fresh request issues the next cycle.
- Reset asserted in WAIT -> next cycle state IDLE, bus_valid 0, want_stall 0 with no op, outputs 0.
